// File: rtl/orb_stream_pkg.sv
// Shared definitions for the ORB result stream: word field positions,
// the sink FSM states and the packed match-pair layout.
package orb_stream_pkg;

    localparam int PIX_MSB = 31;
    localparam int PIX_LSB = 20;
    localparam int X_MSB   = 19;
    localparam int X_LSB   = 10;
    localparam int Y_MSB   = 9;
    localparam int Y_LSB   = 0;

    localparam int COORD_W = 10;
    localparam int PAIR_W  = 40;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        DONE   = 2'd2,
        RESYNC = 2'd3
    } state_t;

    typedef logic [PAIR_W-1:0] pair_t;

    // Pair layout is {y2, x2, y1, x1}, first-half coordinates in the low bits.
    function automatic pair_t make_pair(input logic [COORD_W-1:0] x1,
                                        input logic [COORD_W-1:0] y1,
                                        input logic [COORD_W-1:0] x2,
                                        input logic [COORD_W-1:0] y2);
        return {y2, x2, y1, x1};
    endfunction

endpackage

// File: rtl/orb_match_fifo.sv
// Show-ahead FIFO for match pairs with occupancy count and synchronous clear.
// Latency: write visible at head next cycle; writes while full and reads while empty are ignored.
module orb_match_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 40
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     wr_en,
    input  logic [W-1:0]             wr_data,
    input  logic                     rd_en,
    output logic [W-1:0]             rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
    localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_wr;
    logic          do_rd;

    assign full  = (count == CNT_MAX);
    assign empty = (count == '0);
    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    // Empty head reads as zero so the output never shows stale or unset storage.
    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_rd) rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_wr, do_rd})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/axis_orb_result_sink.sv
// AXI-Stream sink for ORB result words: pixel unpack, match-pair dedup FIFO, line/frame framing.
// Latency: pixel 1 cycle after accept; tready held low during DONE and while the match FIFO is full.
module axis_orb_result_sink
    import orb_stream_pkg::*;
#(
    parameter int H_ACTIVE   = 720,
    parameter int V_ACTIVE   = 480,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          s_axis_aclk,
    input  logic                          s_axis_aresetn,
    input  logic [31:0]                   s_axis_tdata,
    input  logic [3:0]                    s_axis_tkeep,
    input  logic                          s_axis_tlast,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    output logic                          pix_valid,
    output logic [11:0]                   pix_rgb,
    output logic [9:0]                    pix_x,
    output logic [9:0]                    pix_y,
    input  logic                          match_rd_en,
    output logic [PAIR_W-1:0]             match_rd_data,
    output logic                          match_empty,
    output logic [$clog2(FIFO_DEPTH):0]   match_count,
    output logic                          frame_done,
    output logic [15:0]                   frame_cnt,
    input  logic                          status_clr,
    output logic                          line_err,
    output logic                          keep_err
);

    localparam logic [COORD_W-1:0] X_LAST = COORD_W'(H_ACTIVE - 1);
    localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(V_ACTIVE - 1);

    state_t             state;
    logic               running;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic               parity;
    logic [COORD_W-1:0] x1;
    logic [COORD_W-1:0] y1;
    pair_t              last_pair;

    logic               fifo_full;
    logic               accept;
    logic               keep_ok;
    logic               in_frame;
    logic               good;
    logic [COORD_W-1:0] beat_x;
    logic [COORD_W-1:0] beat_y;
    pair_t              pair_cand;
    logic               push;

    // running keeps tready low until the first edge after reset release.
    assign s_axis_tready = running && (state != DONE) && !fifo_full;

    assign accept    = s_axis_tvalid && s_axis_tready;
    assign keep_ok   = (s_axis_tkeep == 4'hF);
    assign in_frame  = (state == IDLE) || (state == RUN);
    assign good      = accept && in_frame && keep_ok;
    assign beat_x    = s_axis_tdata[X_MSB:X_LSB];
    assign beat_y    = s_axis_tdata[Y_MSB:Y_LSB];
    assign pair_cand = make_pair(x1, y1, beat_x, beat_y);
    assign push      = good && parity && (pair_cand != '0) && (pair_cand != last_pair);

    orb_match_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (PAIR_W)
    ) u_fifo (
        .clk     (s_axis_aclk),
        .rst_n   (s_axis_aresetn),
        .clr     (status_clr),
        .wr_en   (push),
        .wr_data (pair_cand),
        .rd_en   (match_rd_en),
        .rd_data (match_rd_data),
        .full    (fifo_full),
        .empty   (match_empty),
        .count   (match_count)
    );

    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            state      <= IDLE;
            running    <= 1'b0;
            x          <= '0;
            y          <= '0;
            parity     <= 1'b0;
            x1         <= '0;
            y1         <= '0;
            last_pair  <= '0;
            pix_valid  <= 1'b0;
            pix_rgb    <= '0;
            pix_x      <= '0;
            pix_y      <= '0;
            frame_done <= 1'b0;
            frame_cnt  <= '0;
            line_err   <= 1'b0;
            keep_err   <= 1'b0;
        end else begin
            running    <= 1'b1;
            frame_done <= 1'b0;
            pix_valid  <= good;
            if (good) begin
                pix_rgb <= s_axis_tdata[PIX_MSB:PIX_LSB];
                pix_x   <= x;
                pix_y   <= y;
                if (!parity) begin
                    x1     <= beat_x;
                    y1     <= beat_y;
                    parity <= 1'b1;
                end else begin
                    parity <= 1'b0;
                end
            end
            if (push) last_pair <= pair_cand;
            if (accept && !keep_ok) keep_err <= 1'b1;

            case (state)
                IDLE, RUN: begin
                    if (accept) begin
                        state <= RUN;
                        if (x == X_LAST) begin
                            if (s_axis_tlast) begin
                                x      <= '0;
                                parity <= 1'b0;
                                if (y == Y_LAST) begin
                                    // frame_done and frame_cnt land together with the DONE cycle.
                                    state      <= DONE;
                                    frame_done <= 1'b1;
                                    frame_cnt  <= frame_cnt + 16'd1;
                                end else begin
                                    y <= y + COORD_W'(1);
                                end
                            end else begin
                                line_err <= 1'b1;
                                state    <= RESYNC;
                            end
                        end else if (s_axis_tlast) begin
                            line_err <= 1'b1;
                            state    <= RESYNC;
                        end else begin
                            x <= x + COORD_W'(1);
                        end
                    end
                end
                RESYNC: begin
                    if (accept && s_axis_tlast) begin
                        x      <= '0;
                        parity <= 1'b0;
                        y      <= (y == Y_LAST) ? '0 : y + COORD_W'(1);
                        state  <= RUN;
                    end
                end
                DONE: begin
                    y     <= '0;
                    state <= RUN;
                end
                default: state <= IDLE;
            endcase

            if (status_clr) begin
                line_err  <= 1'b0;
                keep_err  <= 1'b0;
                last_pair <= '0;
            end
        end
    end

endmodule

// File: tb/tb_axis_orb_result_sink.sv
// Directed bench for axis_orb_result_sink, using a reduced 32x8 raster so whole frames stay short.
module tb_axis_orb_result_sink;

    localparam int H = 32;
    localparam int V = 8;
    localparam int D = 16;

    logic        clk = 1'b0;
    logic        aresetn = 1'b0;
    logic [31:0] tdata = '0;
    logic [3:0]  tkeep = 4'hF;
    logic        tlast = 1'b0;
    logic        tvalid = 1'b0;
    logic        tready;
    logic        pix_valid;
    logic [11:0] pix_rgb;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic        match_rd_en = 1'b0;
    logic [39:0] match_rd_data;
    logic        match_empty;
    logic [4:0]  match_count;
    logic        frame_done;
    logic [15:0] frame_cnt;
    logic        status_clr = 1'b0;
    logic        line_err;
    logic        keep_err;

    int pass_cnt = 0;
    int total = 0;
    int pix_cnt = 0;
    int fd_cnt = 0;
    logic [9:0]  last_px = '0;
    logic [9:0]  last_py = '0;
    logic [11:0] last_rgb = '0;

    always #5 clk = ~clk;

    axis_orb_result_sink #(.H_ACTIVE(H), .V_ACTIVE(V), .FIFO_DEPTH(D)) dut (
        .s_axis_aclk    (clk),
        .s_axis_aresetn (aresetn),
        .s_axis_tdata   (tdata),
        .s_axis_tkeep   (tkeep),
        .s_axis_tlast   (tlast),
        .s_axis_tvalid  (tvalid),
        .s_axis_tready  (tready),
        .pix_valid      (pix_valid),
        .pix_rgb        (pix_rgb),
        .pix_x          (pix_x),
        .pix_y          (pix_y),
        .match_rd_en    (match_rd_en),
        .match_rd_data  (match_rd_data),
        .match_empty    (match_empty),
        .match_count    (match_count),
        .frame_done     (frame_done),
        .frame_cnt      (frame_cnt),
        .status_clr     (status_clr),
        .line_err       (line_err),
        .keep_err       (keep_err)
    );

    always @(negedge clk) begin
        if (pix_valid) begin
            pix_cnt++;
            last_px  = pix_x;
            last_py  = pix_y;
            last_rgb = pix_rgb;
        end
        if (frame_done) fd_cnt++;
    end

    function automatic logic [31:0] w(input logic [11:0] rgb, input logic [9:0] xf,
                                      input logic [9:0] yf);
        return {rgb, xf, yf};
    endfunction

    function automatic logic [39:0] pr(input logic [9:0] y2, input logic [9:0] x2,
                                       input logic [9:0] y1, input logic [9:0] x1);
        return {y2, x2, y1, x1};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Presents one beat and returns just after the negedge that follows its acceptance.
    task automatic send(input logic [31:0] d, input logic last, input logic [3:0] keep);
        int n;
        n = 0;
        tdata = d; tlast = last; tkeep = keep; tvalid = 1'b1;
        while (!tready && n < 100) begin
            @(negedge clk); #1;
            n++;
        end
        if (n >= 100) begin
            check("tready_timeout", 64'(tready), 64'd1);
            $display("%0d/%0d checks passed", pass_cnt, total);
            $fatal(1, "FAIL tready_timeout: sink stalled");
        end
        @(posedge clk);
        @(negedge clk); #1;
        tvalid = 1'b0; tkeep = 4'hF; tlast = 1'b0;
    endtask

    task automatic pop();
        match_rd_en = 1'b1;
        @(negedge clk); #1;
        match_rd_en = 1'b0;
    endtask

    initial begin
        int p;
        logic [9:0] k;

        // Reset state.
        repeat (3) @(negedge clk);
        #1;
        check("rst_tready", 64'(tready), 64'd0);
        check("rst_pix_valid", 64'(pix_valid), 64'd0);
        check("rst_pix", 64'({pix_rgb, pix_x, pix_y}), 64'd0);
        check("rst_empty", 64'(match_empty), 64'd1);
        check("rst_count", 64'(match_count), 64'd0);
        check("rst_rd_data", 64'(match_rd_data), 64'd0);
        check("rst_frame", 64'({frame_done, frame_cnt}), 64'd0);
        check("rst_errs", 64'({line_err, keep_err}), 64'd0);
        aresetn = 1'b1;

        // Frame 1: clean frame, all pairs zero.
        for (int yy = 0; yy < V; yy++)
            for (int xx = 0; xx < H; xx++)
                send(w(12'(xx + yy), 10'd0, 10'd0), xx == H - 1, 4'hF);
        check("f1_frame_done_pulse", 64'(frame_done), 64'd1);
        check("f1_frame_cnt", 64'(frame_cnt), 64'd1);
        check("f1_pix_cnt", 64'(pix_cnt), 64'(H * V));
        check("f1_last_pix", 64'({last_px, last_py, last_rgb}),
              64'({10'd31, 10'd7, 12'd38}));
        check("f1_fifo_empty", 64'(match_empty), 64'd1);
        @(negedge clk); #1;
        check("f1_frame_done_low", 64'(frame_done), 64'd0);
        check("f1_fd_cnt", 64'(fd_cnt), 64'd1);

        // Frame 2 line 0: one pair repeated ten times dedups to one entry.
        for (int xx = 0; xx < H; xx++) begin
            if (xx < 20) send(xx[0] ? w(12'h0, 10'd300, 10'd60) : w(12'h0, 10'd100, 10'd50),
                              xx == H - 1, 4'hF);
            else send(32'd0, xx == H - 1, 4'hF);
        end
        check("dedup_count", 64'(match_count), 64'd1);
        check("dedup_data", 64'(match_rd_data), 64'(pr(10'd60, 10'd300, 10'd50, 10'd100)));
        pop();
        check("dedup_popped_empty", 64'(match_empty), 64'd1);

        // Line 1: sixteen distinct pairs fill the FIFO.
        for (int xx = 0; xx < H; xx++) begin
            k = 10'(xx / 2 + 1);
            send(xx[0] ? w(12'h0, k, 10'd2) : w(12'h0, k, 10'd1), xx == H - 1, 4'hF);
        end
        check("full_tready", 64'(tready), 64'd0);
        check("full_count", 64'(match_count), 64'd16);
        check("full_head", 64'(match_rd_data), 64'(pr(10'd2, 10'd1, 10'd1, 10'd1)));
        repeat (2) @(negedge clk);
        #1;
        check("full_tready_held", 64'(tready), 64'd0);
        pop();
        check("pop_tready", 64'(tready), 64'd1);
        check("pop_count", 64'(match_count), 64'd15);

        // Line 2: the 17th pair is pushed, then the FIFO is drained in order.
        send(w(12'h0, 10'd17, 10'd3), 1'b0, 4'hF);
        send(w(12'h0, 10'd17, 10'd4), 1'b0, 4'hF);
        check("p17_count", 64'(match_count), 64'd16);
        for (int i = 0; i < 16; i++) begin
            k = 10'(i + 2);
            check($sformatf("drain_%0d", i), 64'(match_rd_data),
                  (i < 15) ? 64'(pr(10'd2, k, 10'd1, k)) : 64'(pr(10'd4, 10'd17, 10'd3, 10'd17)));
            pop();
        end
        check("drain_empty", 64'(match_empty), 64'd1);
        for (int xx = 2; xx < H; xx++) send(32'd0, xx == H - 1, 4'hF);

        // Line 3: early tlast at word 20, rest of line dropped.
        for (int xx = 0; xx <= 20; xx++) send(32'd0, xx == 20, 4'hF);
        check("early_tlast_line_err", 64'(line_err), 64'd1);
        p = pix_cnt;
        for (int xx = 21; xx < H; xx++) send(32'd0, xx == H - 1, 4'hF);
        check("resync_no_pixels", 64'(pix_cnt), 64'(p));
        send(w(12'h5A5, 10'd0, 10'd0), 1'b0, 4'hF);
        check("resync_resume", 64'({last_px, last_py, last_rgb}),
              64'({10'd0, 10'd4, 12'h5A5}));
        for (int xx = 1; xx < H; xx++) send(32'd0, xx == H - 1, 4'hF);
        for (int yy = 5; yy < V; yy++)
            for (int xx = 0; xx < H; xx++) send(32'd0, xx == H - 1, 4'hF);
        check("f2_frame_done", 64'(frame_done), 64'd1);
        check("f2_frame_cnt", 64'(frame_cnt), 64'd2);

        // Frame 3 line 0: keep error at x=10.
        for (int xx = 0; xx < 10; xx++) send(32'd0, 1'b0, 4'hF);
        send(w(12'hFFF, 10'd0, 10'd0), 1'b0, 4'h7);
        check("keep_err_set", 64'(keep_err), 64'd1);
        check("keep_no_pix", 64'(pix_valid), 64'd0);
        send(w(12'h111, 10'd0, 10'd0), 1'b0, 4'hF);
        check("keep_next_pix", 64'({pix_valid, pix_x, pix_rgb}),
              64'({1'b1, 10'd11, 12'h111}));
        status_clr = 1'b1;
        @(negedge clk); #1;
        status_clr = 1'b0;
        check("clr_errs", 64'({line_err, keep_err}), 64'd0);
        check("clr_frame_cnt_kept", 64'(frame_cnt), 64'd2);
        for (int xx = 12; xx < H; xx++) send(32'd0, xx == H - 1, 4'hF);

        // Line 1: five pairs, then run into line 5 and reset mid-frame.
        for (int xx = 0; xx < H; xx++) begin
            k = 10'(xx / 2 + 1);
            if (xx < 10) send(xx[0] ? w(12'h0, k, 10'd6) : w(12'h0, k, 10'd5), xx == H - 1, 4'hF);
            else send(32'd0, xx == H - 1, 4'hF);
        end
        check("five_pairs", 64'(match_count), 64'd5);
        for (int yy = 2; yy < 5; yy++)
            for (int xx = 0; xx < H; xx++) send(32'd0, xx == H - 1, 4'hF);
        for (int xx = 0; xx < 7; xx++) send(w(12'h777, 10'd0, 10'd0), 1'b0, 4'hF);
        check("pre_rst_pix_y", 64'(pix_y), 64'd5);
        aresetn = 1'b0;
        #1;
        check("mid_rst_tready", 64'(tready), 64'd0);
        check("mid_rst_fifo", 64'({match_empty, match_count}), 64'({1'b1, 5'd0}));
        check("mid_rst_rd_data", 64'(match_rd_data), 64'd0);
        check("mid_rst_pix", 64'({pix_valid, pix_rgb, pix_x, pix_y}), 64'd0);
        check("mid_rst_frame", 64'({frame_done, frame_cnt}), 64'd0);
        @(negedge clk); #1;
        aresetn = 1'b1;
        send(w(12'hABC, 10'd0, 10'd0), 1'b0, 4'hF);
        check("post_rst_first_pix", 64'({pix_valid, pix_rgb, pix_x, pix_y}),
              64'({1'b1, 12'hABC, 10'd0, 10'd0}));

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
